// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   state_t  : arbiter operating state (zero-fill or normal service)
//   DEF_N    : default data width
//   DEF_M    : default address width
//   rr_pick  : round-robin pick over up to 8 requesters, returns a one-hot grant
package sram_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_N = 64;
  localparam int DEF_M = 12;

  // First valid requester found searching upward from ptr, wrapping at nreq.
  // ptr is always below nreq, so one conditional subtract replaces a modulo.
  function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input logic [3:0] nreq);
    logic [7:0] pick;
    logic [3:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (4'(k) < nreq) && valid[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_port_arb_rr_grant.sv
// Round-robin priority selector: combinational one-hot grant plus the
// registered rotation pointer.
//   clk, rst_n : clock, async active-low reset
//   en         : grant permitted this cycle
//   valid      : per-requester request
//   grant      : one-hot grant (all zero when nothing valid or en low)
module rr_grant
  import sram_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant
);

  logic [2:0] ptr;
  logic [2:0] pick_idx;
  logic [7:0] valid8;
  logic [7:0] pick8;
  logic       hit;

  always_comb begin
    valid8            = '0;
    valid8[NREQ-1:0]  = valid;
    pick8             = en ? rr_pick(valid8, ptr, 4'(NREQ)) : 8'h00;
    pick_idx          = '0;
    hit               = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (pick8[k]) begin
        pick_idx = 3'(k);
        hit      = 1'b1;
      end
    end
    grant = pick8[NREQ-1:0];
  end

  // Every grant is a handshake, so the pointer moves past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (hit) ptr <= (pick_idx == 3'(NREQ-1)) ? 3'd0 : pick_idx + 3'd1;
  end

endmodule

// File: rtl/sram_port_arb.sv
// Round-robin arbiter sharing one SRAM port among NREQ requesters.
// Optional boot zero-fill enabled by macro SRAM_ARB_INIT_EN.
//   req_valid/we/addr/wdata : flattened per-requester commands
//   req_ready               : one-hot combinational grant
//   rsp_valid/rsp_rdata     : one-hot read return, 2 cycles after handshake
//   init_done               : arbiter is serving requests
//   sram_en/we/addr/din     : registered SRAM port command
//   sram_dout               : SRAM read data (one cycle after read enable)
module sram_port_arb
  import sram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int N    = DEF_N,
  parameter int M    = DEF_M
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*M-1:0] req_addr,
  input  logic [NREQ*N-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_rdata,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_we,
  output logic [M-1:0]      sram_addr,
  output logic [N-1:0]      sram_din,
  input  logic [N-1:0]      sram_dout
);

  logic            run;
  logic            init_fill;
  logic [M-1:0]    fill_cnt;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] rd_tag;
  logic            hs;
  logic            sel_we;
  logic [M-1:0]    sel_addr;
  logic [N-1:0]    sel_wdata;

`ifdef SRAM_ARB_INIT_EN
  state_t state_q, state_d;
  logic   init_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      fill_cnt    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_q == ST_RUN);
      if (state_q == ST_INIT) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (&fill_cnt) state_d = ST_RUN;
      default: state_d = state_q;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign init_fill = (state_q == ST_INIT);
  assign init_done = init_done_q;
`else
  assign run       = 1'b1;
  assign init_fill = 1'b0;
  assign fill_cnt  = '0;
  assign init_done = 1'b1;
`endif

  // rst_n gates the grant so req_ready reads zero while reset is held.
  rr_grant #(.NREQ(NREQ)) u_rr_grant (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run & rst_n),
    .valid (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign hs        = |grant;
  assign rsp_rdata = sram_dout;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*M +: M];
        sel_wdata = req_wdata[i*N +: N];
      end
    end
  end

  // rd_tag marks the requester whose read is on the port this cycle;
  // rsp_valid follows one cycle later, aligned with sram_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_en   <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      rd_tag    <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= rd_tag;
      rd_tag    <= '0;
      if (init_fill) begin
        sram_en   <= 1'b1;
        sram_we   <= 1'b1;
        sram_addr <= fill_cnt;
        sram_din  <= '0;
      end else if (hs) begin
        sram_en   <= 1'b1;
        sram_we   <= sel_we;
        sram_addr <= sel_addr;
        sram_din  <= sel_wdata;
        if (!sel_we) rd_tag <= grant;
      end else begin
        sram_en <= 1'b0;
        sram_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arb.sv
module tb_sram_port_arb;

  localparam int NREQ = 4;
  localparam int N    = 64;
  localparam int M    = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_we = '0;
  logic [NREQ*M-1:0] req_addr = '0;
  logic [NREQ*N-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_rdata;
  logic              init_done;
  logic              sram_en, sram_we;
  logic [M-1:0]      sram_addr;
  logic [N-1:0]      sram_din;
  logic [N-1:0]      sram_dout;

  sram_port_arb #(.NREQ(NREQ), .N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single port of the SRAM
  logic [N-1:0] mem [4096];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout      <= mem[sram_addr];
    end
  end

`ifdef SRAM_ARB_INIT_EN
  localparam logic INIT_DONE_RST = 1'b0;
`else
  localparam logic INIT_DONE_RST = 1'b1;
`endif

  typedef struct {
    int         due;
    logic [3:0] tag;
    logic [63:0] data;
  } rsp_t;

  rsp_t        q[$];
  logic [63:0] ref_mem [4096];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mptr = 0;
  logic        exp_en = 1'b0, exp_we = 1'b0;
  logic [11:0] exp_addr = '0;
  logic [63:0] exp_din = '0;
  logic [11:0] sa [4];
  logic [63:0] sd [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_winner(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // One clock cycle: drive a command set, then check grant, port and response.
  task automatic step(input logic [3:0] v, input logic [3:0] w);
    int          win;
    logic [3:0]  eg;
    logic [3:0]  er;
    @(posedge clk); #1;
    req_valid = v;
    req_we    = w;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*M +: M]  = sa[i];
      req_wdata[i*N +: N] = sd[i];
    end
    @(negedge clk);
    win = exp_winner(v, mptr);
    eg  = (win >= 0) ? 4'(1 << win) : 4'b0000;
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("init_done", 64'(init_done), 64'(1));
    chk("sram_en", 64'(sram_en), 64'(exp_en));
    chk("sram_we", 64'(sram_we), 64'(exp_we));
    chk("sram_addr", 64'(sram_addr), 64'(exp_addr));
    chk("sram_din", sram_din, exp_din);
    er = (q.size() > 0 && q[0].due == cyc) ? q[0].tag : 4'b0000;
    chk("rsp_valid", 64'(rsp_valid), 64'(er));
    if (er != 4'b0000) begin
      chk("rsp_rdata", rsp_rdata, q[0].data);
      void'(q.pop_front());
    end
    if (win >= 0) begin
      mptr     = (win + 1) % 4;
      exp_en   = 1'b1;
      exp_we   = w[win];
      exp_addr = sa[win];
      exp_din  = sd[win];
      if (w[win]) ref_mem[sa[win]] = sd[win];
      else        q.push_back('{due: cyc + 2, tag: eg, data: ref_mem[sa[win]]});
    end else begin
      exp_en = 1'b0;
      exp_we = 1'b0;
    end
  endtask

`ifdef SRAM_ARB_INIT_EN
  task automatic init_fill();
    req_valid = 4'hF;
    req_we    = 4'h0;
    for (int k = 0; k < 4096; k++) begin
      @(posedge clk);
      if (k == 4095) begin #1; req_valid = '0; end
      @(negedge clk);
      chk("init_ready", 64'(req_ready), 64'(0));
      chk("init_cmd", {sram_en, sram_we, 50'(sram_addr)}, {2'b11, 50'(k)});
      chk("init_din", sram_din, 64'(0));
      chk("init_done_lo", 64'(init_done), 64'(0));
      chk("init_rsp", 64'(rsp_valid), 64'(0));
    end
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    exp_en   = 1'b0;
    exp_we   = 1'b0;
    exp_addr = 12'hFFF;
    exp_din  = '0;
  endtask
`endif

  // Async reset mid-cycle; current req_valid stays applied to prove gating.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp", 64'(rsp_valid), 64'(0));
    chk("rst_en_we", {62'(0), sram_en, sram_we}, 64'(0));
    chk("rst_addr", 64'(sram_addr), 64'(0));
    chk("rst_din", sram_din, 64'(0));
    chk("rst_init_done", 64'(init_done), 64'(INIT_DONE_RST));
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    mptr     = 0;
    exp_en   = 1'b0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_din  = '0;
`ifdef SRAM_ARB_INIT_EN
    init_fill();
`endif
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      sa[i] = '0;
      sd[i] = '0;
    end
    do_reset();

    // Single write then read of 0x005 by requester 1
    sa[0] = 12'h005; sd[0] = 64'hDEADBEEF_00000001;
    step(4'b0001, 4'b0001);
    sa[1] = 12'h005;
    step(4'b0010, 4'b0000);
    repeat (3) step(4'b0000, 4'b0000);

    // All four valid: writes then continuous reads, grants rotate each cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sa[i] = 12'h010 + 12'(i);
      sd[i] = {32'hA5A5_0000, 32'(i * 17 + 3)};
    end
    repeat (4) step(4'b1111, 4'b1111);
    repeat (8) step(4'b1111, 4'b0000);
    repeat (2) step(4'b0000, 4'b0000);

    // Fairness with idle requesters 1 and 3
    repeat (5) step(4'b0101, 4'b0000);
    repeat (2) step(4'b0000, 4'b0000);

    // Interleaved write/read of one address from two requesters
    sa[0] = 12'h040; sa[3] = 12'h040;
    for (int k = 0; k < 4; k++) begin
      sd[0] = {32'hC0DE_0000, 32'(k)};
      step(4'b0001, 4'b0001);
      step(4'b1000, 4'b0000);
    end
    repeat (3) step(4'b0000, 4'b0000);

    // Reset asserted in the cycle after a read handshake
    sa[1] = 12'h040;
    step(4'b0010, 4'b0000);
    do_reset();
    repeat (4) step(4'b0000, 4'b0000);

    // Random mixed traffic over a small address pool
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) begin
        sa[i] = 12'h7F0 + 12'($urandom_range(0, 7));
        sd[i] = {$urandom, $urandom};
      end
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    sa[2] = 12'hFFF;
    step(4'b0100, 4'b0000);
    repeat (3) step(4'b0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
